// File: rtl/seg_marquee.sv
`default_nettype none
// ============================================================================
// Module   : seg_marquee
// Brief    : Multiplexed common-anode 7-segment scrolling text driver with a
//            writable character RAM, runtime length, scroll control, blanking.
// Revision : 1.0 - initial release
// ============================================================================
module seg_marquee #(
  parameter int DIGITS    = 4,
  parameter int MSG_DEPTH = 16,
  parameter int MUX_DIV   = 65536,
  parameter int BLANK     = 16,
  localparam int AW       = $clog2(MSG_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [6:0]        wr_data,
  input  logic [AW:0]       msg_len,
  input  logic              scroll_en,
  input  logic              scroll_dir,
  input  logic [7:0]        scroll_period,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] dig_n,
  output logic              frame_tick,
  output logic              wrap
);

  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int SW = (MUX_DIV > 1) ? $clog2(MUX_DIV) : 1;
  localparam int LW = AW + 1;
  localparam int XW = AW + 2;

  localparam logic [SW-1:0] c_slot_last = SW'(MUX_DIV - 1);
  localparam logic [SW-1:0] c_blank     = SW'(BLANK);
  localparam logic [DW-1:0] c_dig_last  = DW'(DIGITS - 1);
  localparam logic [LW-1:0] c_depth     = LW'(MSG_DEPTH);

  logic [6:0]        ram_q [MSG_DEPTH];

  logic [SW-1:0]     slot_cnt_q,   slot_cnt_d;
  logic [DW-1:0]     dig_idx_q,    dig_idx_d;
  logic [7:0]        scroll_cnt_q, scroll_cnt_d;
  logic [AW-1:0]     head_q,       head_d;
  logic [6:0]        seg_q,        seg_d;
  logic              show_q,       show_d;
  logic [DIGITS-1:0] dig_n_q,      dig_n_d;
  logic              frame_tick_q, frame_tick_d;
  logic              wrap_q,       wrap_d;

  logic [LW-1:0]     eff_len;
  logic              len_zero;
  logic              slot_last;
  logic              slot_start;
  logic [XW-1:0]     rd_sum;
  logic [XW-1:0]     rd_div;
  logic [AW-1:0]     rd_idx;
  logic [7:0]        period_m1;
  logic              step_due;

  // Character RAM survives reset so the message persists across it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      ram_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    eff_len    = (msg_len > c_depth) ? c_depth : msg_len;
    len_zero   = (eff_len == '0);
    slot_last  = (slot_cnt_q == c_slot_last);
    slot_start = (slot_cnt_q == '0);

    slot_cnt_d = slot_last ? '0 : slot_cnt_q + SW'(1);
    dig_idx_d  = dig_idx_q;
    if (slot_last) begin
      dig_idx_d = (dig_idx_q == c_dig_last) ? '0 : dig_idx_q + DW'(1);
    end
    frame_tick_d = (slot_cnt_d == c_slot_last) && (dig_idx_d == c_dig_last);

    // Leftmost digit (highest index) shows the head character.
    rd_sum = XW'(head_q) + XW'(DIGITS - 1) - XW'(dig_idx_q);
    rd_div = len_zero ? XW'(1) : XW'(eff_len);
    rd_idx = AW'(rd_sum % rd_div);

    // Fetch and enable decision are latched once per slot to avoid tearing.
    seg_d  = seg_q;
    show_d = show_q;
    if (slot_start) begin
      seg_d  = len_zero ? 7'd0 : ram_q[rd_idx];
      show_d = !len_zero;
    end

    dig_n_d = '1;
    if (show_d && (slot_cnt_d >= c_blank)) begin
      dig_n_d = ~(DIGITS'(1) << dig_idx_d);
    end

    period_m1 = (scroll_period == 8'd0) ? 8'd0 : scroll_period - 8'd1;
    step_due  = frame_tick_q && scroll_en && (scroll_cnt_q >= period_m1);

    scroll_cnt_d = scroll_cnt_q;
    if (!scroll_en) begin
      scroll_cnt_d = 8'd0;
    end else if (frame_tick_q) begin
      scroll_cnt_d = step_due ? 8'd0 : scroll_cnt_q + 8'd1;
    end

    // A shrunken length overrides any pending step and never signals wrap.
    head_d = head_q;
    wrap_d = 1'b0;
    if (LW'(head_q) >= eff_len) begin
      head_d = '0;
    end else if (step_due) begin
      if (!scroll_dir) begin
        head_d = ((LW'(head_q) + LW'(1)) == eff_len) ? '0 : head_q + AW'(1);
      end else begin
        head_d = (head_q == '0) ? AW'(eff_len - LW'(1)) : head_q - AW'(1);
      end
      wrap_d = (head_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt_q   <= '0;
      dig_idx_q    <= '0;
      scroll_cnt_q <= 8'd0;
      head_q       <= '0;
      seg_q        <= 7'd0;
      show_q       <= 1'b0;
      dig_n_q      <= '1;
      frame_tick_q <= 1'b0;
      wrap_q       <= 1'b0;
    end else begin
      slot_cnt_q   <= slot_cnt_d;
      dig_idx_q    <= dig_idx_d;
      scroll_cnt_q <= scroll_cnt_d;
      head_q       <= head_d;
      seg_q        <= seg_d;
      show_q       <= show_d;
      dig_n_q      <= dig_n_d;
      frame_tick_q <= frame_tick_d;
      wrap_q       <= wrap_d;
    end
  end

  assign seg        = seg_q;
  assign dig_n      = dig_n_q;
  assign frame_tick = frame_tick_q;
  assign wrap       = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_marquee.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_marquee
// Brief    : Self-checking bench for seg_marquee (4 digits, 8-deep RAM).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_marquee;

  localparam int D     = 4;
  localparam int DEPTH = 8;
  localparam int MUX   = 8;
  localparam int BL    = 2;
  localparam int AW    = 3;
  localparam int FRAME = D * MUX;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [6:0]    wr_data;
  logic [AW:0]   msg_len;
  logic          scroll_en;
  logic          scroll_dir;
  logic [7:0]    scroll_period;
  logic [6:0]    seg;
  logic [D-1:0]  dig_n;
  logic          frame_tick;
  logic          wrap;

  int checks   = 0;
  int errors   = 0;
  int cyc      = 0;
  int t        = 0;
  int m_head   = 0;
  int m_scnt   = 0;
  int wrap_cnt = 0;
  logic       chk_en = 1'b0;
  logic [6:0] m_seg  = 7'd0;
  logic       m_show = 1'b0;
  logic       m_wrap = 1'b0;
  logic [6:0] m_ram [DEPTH];
  logic [6:0] vals  [DEPTH];

  seg_marquee #(
    .DIGITS   (D),
    .MSG_DEPTH(DEPTH),
    .MUX_DIV  (MUX),
    .BLANK    (BL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .msg_len      (msg_len),
    .scroll_en    (scroll_en),
    .scroll_dir   (scroll_dir),
    .scroll_period(scroll_period),
    .seg          (seg),
    .dig_n        (dig_n),
    .frame_tick   (frame_tick),
    .wrap         (wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int eff_f(input logic [AW:0] ml);
    return (int'(ml) > DEPTH) ? DEPTH : int'(ml);
  endfunction

  function automatic logic [6:0] fetch_char(input int h, input int k, input int e);
    if (e == 0) return 7'd0;
    return m_ram[3'((h + D - 1 - k) % e)];
  endfunction

  function automatic bit due_f(input int tt, input int scnt);
    int per;
    per = (scroll_period == 8'd0) ? 1 : int'(scroll_period);
    return ((tt % FRAME) == FRAME - 1) && (scroll_en == 1'b1) && (scnt >= per - 1);
  endfunction

  function automatic int next_head(input int h, input int e, input bit step, input bit dir);
    if (h >= e) return 0;
    if (!step) return h;
    if (dir) return (h == 0) ? e - 1 : h - 1;
    return (h + 1) % e;
  endfunction

  function automatic bit wrap_f(input int h, input int e, input bit step, input bit dir);
    return (h < e) && step && (next_head(h, e, step, dir) == 0);
  endfunction

  function automatic logic [3:0] exp_dig(input int tt, input logic show);
    logic [3:0] one;
    one = 4'b0001;
    if (((tt % MUX) >= BL) && show) return ~(one << ((tt / MUX) % D));
    return 4'hF;
  endfunction

  // Reference model: slot position derived from cycles since reset.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (wr_en) m_ram[wr_addr] <= wr_data;
    if (rst) begin
      t      <= 0;
      m_head <= 0;
      m_scnt <= 0;
      m_seg  <= 7'd0;
      m_show <= 1'b0;
      m_wrap <= 1'b0;
    end else begin
      t <= t + 1;
      if ((t % MUX) == 0) begin
        m_seg  <= fetch_char(m_head, (t / MUX) % D, eff_f(msg_len));
        m_show <= (eff_f(msg_len) != 0);
      end
      m_head <= next_head(m_head, eff_f(msg_len), due_f(t, m_scnt), scroll_dir);
      m_wrap <= wrap_f(m_head, eff_f(msg_len), due_f(t, m_scnt), scroll_dir);
      if (!scroll_en) m_scnt <= 0;
      else if ((t % FRAME) == FRAME - 1) m_scnt <= due_f(t, m_scnt) ? 0 : m_scnt + 1;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("seg", 32'(seg), 32'(m_seg));
        chk("dig_n", 32'(dig_n), 32'(exp_dig(t, m_show)));
        chk("frame_tick", 32'(frame_tick), 32'(((t % FRAME) == FRAME - 1) ? 1 : 0));
        chk("wrap", 32'(wrap), 32'(m_wrap));
        if (wrap === 1'b1) wrap_cnt++;
      end
    end
  end

  task automatic wait_tc(input int k, input int c);
    int n;
    n = 0;
    @(negedge clk);
    while (!(((t % MUX) == c) && (((t / MUX) % D) == k)) && (n < 200)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("slot_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_pulse(input bit use_wrap, input int lim, output int at);
    at = -1;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if ((use_wrap ? wrap : frame_tick) === 1'b1) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) chk("pulse_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int a;
    int b;
    int w0;
    int n;
    vals[0] = 7'h01; vals[1] = 7'h02; vals[2] = 7'h04; vals[3] = 7'h08;
    vals[4] = 7'h10; vals[5] = 7'h20; vals[6] = 7'h40; vals[7] = 7'h03;
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; msg_len = '0;
    scroll_en = 1'b0; scroll_dir = 1'b0; scroll_period = 8'd0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i); wr_data = vals[i];
      @(posedge clk); #1;
    end
    wr_en = 1'b0;
    chk("reset_dig_n", 32'(dig_n), 32'hF);
    chk("reset_seg", 32'(seg), 32'h0);
    msg_len = 4'd4;
    rst = 1'b0;

    // Static display
    wait_tc(0, 1);
    chk("static_d0_seg", 32'(seg), 32'h08);
    chk("static_d0_blank", 32'(dig_n), 32'hF);
    wait_tc(0, 2);
    chk("static_d0_on", 32'(dig_n), 32'hE);
    wait_tc(3, 1);
    chk("static_d3_seg", 32'(seg), 32'h01);
    wait_tc(3, 5);
    chk("static_d3_on", 32'(dig_n), 32'h7);
    wait_pulse(1'b0, 100, a);
    wait_pulse(1'b0, 100, b);
    chk("frame_period", 32'(b - a), 32'd32);

    // Forward scroll, two frames per step over six characters
    msg_len = 4'd6; scroll_period = 8'd2; scroll_dir = 1'b0; scroll_en = 1'b1;
    wait_pulse(1'b1, 1000, a);
    wait_pulse(1'b1, 1000, b);
    chk("wrap_period", 32'(b - a), 32'd384);
    @(negedge clk);
    chk("wrap_width", 32'(wrap), 32'd0);

    // Reverse scroll from head 0
    scroll_dir = 1'b1;
    w0 = wrap_cnt;
    wait_tc(3, 1);
    chk("rev_pre_d3", 32'(seg), 32'h01);
    wait_tc(0, 1);
    chk("rev_pre_d0", 32'(seg), 32'h08);
    wait_tc(0, 1);
    chk("rev_post_d0", 32'(seg), 32'h04);
    wait_tc(3, 1);
    chk("rev_post_d3", 32'(seg), 32'h20);
    chk("rev_no_wrap", 32'(wrap_cnt - w0), 32'd0);
    scroll_en = 1'b0;

    // Short message with head 2, then shrink
    msg_len = 4'd3; scroll_period = 8'd1; scroll_dir = 1'b0; scroll_en = 1'b1;
    n = 0;
    while ((m_head != 2) && (n < 200)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("head2_timeout", 32'd0, 32'd1);
    scroll_en = 1'b0;
    wait_tc(0, 1);
    chk("short_d0", 32'(seg), 32'h04);
    wait_tc(2, 1);
    chk("short_d2", 32'(seg), 32'h01);
    msg_len = 4'd2;
    @(negedge clk);
    chk("shrink_head", 32'(m_head), 32'd0);
    chk("shrink_wrap", 32'(wrap), 32'd0);
    wait_tc(0, 1);
    chk("shrink_d0", 32'(seg), 32'h02);

    // Empty message, then scroll_period of zero
    msg_len = 4'd0;
    wait_tc(1, 5);
    chk("empty_dig_n", 32'(dig_n), 32'hF);
    chk("empty_seg", 32'(seg), 32'h0);
    msg_len = 4'd4; scroll_period = 8'd0; scroll_dir = 1'b0; scroll_en = 1'b1;
    wait_tc(3, 1);
    chk("p0_step0", 32'(seg), 32'h01);
    wait_tc(3, 1);
    chk("p0_step1", 32'(seg), 32'h02);
    wait_tc(3, 1);
    chk("p0_step2", 32'(seg), 32'h04);
    scroll_en = 1'b0;

    // Reset in the middle of slot 2
    wait_tc(2, 5);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_dig_n", 32'(dig_n), 32'hF);
    chk("mid_rst_seg", 32'(seg), 32'h0);
    chk("mid_rst_head", 32'(m_head), 32'd0);
    wait_tc(0, 1);
    chk("post_rst_d0", 32'(seg), 32'h08);
    wait_tc(3, 1);
    chk("post_rst_d3", 32'(seg), 32'h01);

    repeat (4) @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg_marquee.md
# seg_marquee

Parametrised multiplexed 7-segment scrolling text driver for the board's common-anode digit bank. It is the general-purpose successor to the fixed four-digit banner. The message is held in a writable character RAM with runtime length. Scroll rate, direction and enable are runtime-controlled, and anti-ghosting blanking is applied between digit slots. It sits between any character-producing logic and the `pio` segment/digit pins.

## Interface
Parameters:
- `DIGITS`, default 4: number of multiplexed digits, 2..8.
- `MSG_DEPTH`, default 16: character RAM depth, power of two, ≥ `DIGITS`.
- `MUX_DIV`, default 65536: clock cycles per digit slot.
- `BLANK`, default 16: cycles at the start of each slot with all digits off. Requires 1 ≤ `BLANK` < `MUX_DIV`.
- `AW`: `$clog2(MSG_DEPTH)`. Derived, not overridable.

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `wr_en`, in, 1: character write strobe.
- `wr_addr`, in, `AW`: character RAM address.
- `wr_data`, in, 7: segment pattern, bit 0 = segment a, active-high.
- `msg_len`, in, `AW+1`: message length, 0..`MSG_DEPTH`.
- `scroll_en`, in, 1: 1 = scroll, 0 = static.
- `scroll_dir`, in, 1: 0 = text moves left (head +1), 1 = moves right (head −1).
- `scroll_period`, in, 8: refresh frames per scroll step.
- `seg`, out, 7: active-high segment drive.
- `dig_n`, out, `DIGITS`: active-low one-cold digit select. Bit `DIGITS-1` is the leftmost digit.
- `frame_tick`, out, 1: one-cycle pulse at the end of each refresh frame.
- `wrap`, out, 1: one-cycle pulse when `head` becomes 0 by scrolling.

## Operation
- Character RAM: `MSG_DEPTH` × 7 bits. Written on `wr_en` at `wr_addr`. Not cleared by `rst`.
- `eff_len` = min(`msg_len`, `MSG_DEPTH`).
- Digit k (k = 0 is rightmost) shows RAM[(`head` + `DIGITS`−1−k) mod `eff_len`]. If `eff_len` < `DIGITS`, characters repeat cyclically.
- If `eff_len` = 0: `seg` = 0 and `dig_n` stays all-ones. Counters keep running, `head` is held at 0, and `wrap` never fires.
- Slot counter runs 0..`MUX_DIV`−1. At the terminal count, digit index advances in the order 0,1,…,`DIGITS`−1,0.
- A refresh frame is `DIGITS` slots. `frame_tick` pulses on the last cycle of slot `DIGITS`−1.
- Scroll counter advances on each `frame_tick`. When `scroll_en`=1 and the counter reaches max(`scroll_period`,1)−1:
  - the counter clears;
  - `head` steps by +1 or −1 according to `scroll_dir`, modulo `eff_len` (0−1 → `eff_len`−1);
  - `wrap` pulses in the same cycle that `head` is loaded with 0.
- When `scroll_en`=0, the scroll counter holds at 0 and `head` holds.
- If `head` ≥ `eff_len` (the length shrank), `head` is forced to 0 on the next cycle. This takes priority over a scroll step and does not pulse `wrap`.
- A write to a displayed address takes effect from the next slot fetch. There is no tearing within a slot.

## Timing
- Reset values: `seg`=0, `dig_n`=all ones, `frame_tick`=0, `wrap`=0. All counters, digit index and `head` are 0.
- The first slot after reset is digit 0, with slot count 0 on the first cycle after `rst` deasserts.
- Slot cycle c = 0: RAM address computed and read.
  - c ≥ 1: `seg` shows the slot's character, registered.
  - c < `BLANK`: `dig_n` = all ones.
  - c ≥ `BLANK`: `dig_n` bit i = 0 for the active digit i.
  - `seg` and `dig_n` change only on slot boundaries or at c = 1 / c = `BLANK`.
- `head` updates on the cycle after `frame_tick`, so a new scroll position is shown from slot 0 of the next frame.
- A `scroll_dir` or `scroll_period` change takes effect at the next step evaluation. No step is lost or doubled.
- A `rst` assertion mid-slot returns all state to reset values on the next edge.

## Test plan
All scenarios use `DIGITS`=4, `MSG_DEPTH`=8, `MUX_DIV`=8, `BLANK`=2.

1. Static display:
   - Stimulus: write RAM[0..3] = 0x01, 0x02, 0x04, 0x08; `msg_len`=4; `scroll_en`=0.
   - Response: slot k shows `seg` = RAM[3−k]. `dig_n` is 1111 at c = 0..1, then has bit k low at c = 2..7. `frame_tick` fires every 32 cycles.
2. Forward scroll and wrap:
   - Stimulus: `msg_len`=6, `scroll_period`=2, `scroll_dir`=0, `scroll_en`=1.
   - Response: `head` steps 0→1→…→5→0, one step every 64 cycles. `wrap` is one cycle wide at the 5→0 step.
3. Reverse scroll:
   - Stimulus: `scroll_dir`=1 from `head`=0, `msg_len`=6.
   - Response: next `head` = 5; leftmost digit shows RAM[5]; `wrap` stays 0 on that step.
4. Short message and length shrink:
   - Stimulus: `msg_len`=3 with `head`=2; digit-0 check; then `msg_len`→2.
   - Response: with `head`=2, digit 0 shows RAM[(2+3) mod 3] = RAM[2]. After the shrink, `head` = 0 on the next cycle and `wrap`=0.
5. Empty message and `scroll_period`=0:
   - Stimulus: `msg_len`=0; then `msg_len`=4, `scroll_period`=0.
   - Response: with `msg_len`=0, `dig_n` stays 1111 and `seg`=0. Afterwards, `head` steps once per frame (period treated as 1).
6. Reset mid-slot:
   - Stimulus: assert `rst` at slot 2, c = 5, for one cycle.
   - Response: next cycle `dig_n`=1111, `seg`=0, `head`=0. RAM contents are intact and displayed again from slot 0.
